// File: rtl/seg_scan_ctrl.sv
// Scan/flash timing and frame-synchronous display buffer for the 7-seg decoder.
// Optional flash generator built only when SEG_FLASH_EN is defined.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int FLASH_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_le,
  input  logic [7:0]  wr_point,
  input  logic        flash_en,
  output logic [31:0] data,
  output logic [7:0]  le,
  output logic [7:0]  point,
  output logic [2:0]  scan,
  output logic        flash,
  output logic        frame_tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } wst_t;

  wst_t st;
  wst_t st_nx;

  logic [DW-1:0] div;
  logic          div_last;
  logic          pending;
  logic          accept;
  logic          commit;
  logic [31:0]   pdata;
  logic [7:0]    ple;
  logic [7:0]    ppoint;

  assign div_last   = (div == DIV_LAST);
  assign frame_tick = div_last && (scan == 3'd7);
  assign accept     = wr_valid && wr_ready;
  assign commit     = frame_tick && pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      scan <= 3'd0;
    end else if (div_last) begin
      div  <= '0;
      scan <= scan + 3'd1;
    end else begin
      div  <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (accept)     st_nx = HOLD;
      HOLD: if (frame_tick) st_nx = IDLE;
      default:              st_nx = IDLE;
    endcase
  end

  always_comb begin
    pending  = (st == HOLD);
    wr_ready = !pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pdata  <= '0;
      ple    <= '0;
      ppoint <= '0;
    end else if (accept) begin
      pdata  <= wr_data;
      ple    <= wr_le;
      ppoint <= wr_point;
    end
  end

  // New contents land on the frame edge, so they appear with scan=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      le    <= '0;
      point <= '0;
    end else if (commit) begin
      data  <= pdata;
      le    <= ple;
      point <= ppoint;
    end
  end

`ifdef SEG_FLASH_EN
  localparam logic [FW-1:0] FC_LAST = FW'(FLASH_FRAMES - 1);

  logic [FW-1:0] fc;
  logic          flash_q;

  always_ff @(posedge clk) begin
    if (rst || !flash_en) begin
      fc      <= '0;
      flash_q <= 1'b0;
    end else if (frame_tick) begin
      if (fc == FC_LAST) begin
        fc      <= '0;
        flash_q <= !flash_q;
      end else begin
        fc      <= fc + 1'b1;
      end
    end
  end

  assign flash = flash_q;
`else
  logic unused_flash_en;
  assign unused_flash_en = flash_en;
  assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table vectors, directed corner sequences and
// randomized traffic checked against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int SD = 4;
  localparam int FF = 2;
  localparam int FRAME = 8 * SD;
`ifdef SEG_FLASH_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_le = '0;
  logic [7:0]  wr_point = '0;
  logic        flash_en = 1'b0;
  logic [31:0] data;
  logic [7:0]  le;
  logic [7:0]  point;
  logic [2:0]  scan;
  logic        flash;
  logic        frame_tick;

  seg_scan_ctrl #(
    .SCAN_DIV(SD),
    .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .wr_le(wr_le),
    .wr_point(wr_point),
    .flash_en(flash_en),
    .data(data),
    .le(le),
    .point(point),
    .scan(scan),
    .flash(flash),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // Reference model: time since reset plus a one-deep write buffer.
  int          m_t = 0;
  bit          m_pend = 0;
  bit          m_acc = 0;
  logic [31:0] m_pd = '0, m_d = '0;
  logic [7:0]  m_ple = '0, m_pp = '0, m_le = '0, m_p = '0;
  int          m_ticks = 0;
  bit          m_fl = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_step();
    bit tick;
    tick = (m_t % FRAME) == FRAME - 1;
    if (rst) begin
      m_t = 0; m_pend = 0; m_acc = 0;
      m_d = '0; m_le = '0; m_p = '0;
      m_ticks = 0; m_fl = 0;
      return;
    end
    m_acc = wr_valid && !m_pend;
    if (tick && m_pend) begin
      m_d = m_pd; m_le = m_ple; m_p = m_pp;
      m_pend = 0;
    end
    if (m_acc) begin
      m_pd = wr_data; m_ple = wr_le; m_pp = wr_point;
      m_pend = 1;
    end
`ifdef SEG_FLASH_EN
    if (!flash_en) begin
      m_ticks = 0; m_fl = 0;
    end else if (tick) begin
      m_ticks++;
      m_fl = ((m_ticks / FF) % 2) == 1;
    end
`else
    m_fl = 0;
`endif
    m_t++;
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [2:0] s;
    logic       t;
    s = 3'((m_t / SD) % 8);
    t = (m_t % FRAME) == FRAME - 1;
    return {10'b0, m_d, m_le, m_p, s, m_fl, t, !m_pend};
  endfunction

  function automatic logic [63:0] act_vec();
    return {10'b0, data, le, point, scan, flash, frame_tick, wr_ready};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model", act_vec(), exp_vec());
  endtask

  task automatic wait_scan(input logic [2:0] s);
    int k = 0;
    while (scan !== s && k < 40) begin
      cyc();
      k++;
    end
    if (scan !== s) chk("wait_scan_timeout", 64'(scan), 64'(s));
  endtask

  task automatic wait_tick();
    int k = 0;
    while (frame_tick !== 1'b1 && k < 40) begin
      cyc();
      k++;
    end
    if (frame_tick !== 1'b1) chk("wait_tick_timeout", 64'(frame_tick), 64'd1);
  endtask

  typedef struct {
    int         n;
    logic [2:0] scan;
    logic       tick;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int cur;
    int ticks;
    int vis;

    tbl[0] = '{0, 3'd0, 1'b0};
    tbl[1] = '{3, 3'd0, 1'b0};
    tbl[2] = '{4, 3'd1, 1'b0};
    tbl[3] = '{7, 3'd1, 1'b0};
    tbl[4] = '{8, 3'd2, 1'b0};
    tbl[5] = '{30, 3'd7, 1'b0};
    tbl[6] = '{31, 3'd7, 1'b1};
    tbl[7] = '{32, 3'd0, 1'b0};
    tbl[8] = '{36, 3'd1, 1'b0};
    tbl[9] = '{63, 3'd7, 1'b1};

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_outs", {data, le, point, scan, flash, frame_tick}, '0);
    chk("rst_ready", 64'(wr_ready), 64'd1);
    rst = 1'b0;

    cur = 0;
    ticks = 0;
    foreach (tbl[i]) begin
      while (cur < tbl[i].n) begin
        cyc();
        cur++;
        if (frame_tick === 1'b1) ticks++;
      end
      chk($sformatf("tbl%0d_scan", i), 64'(scan), 64'(tbl[i].scan));
      chk($sformatf("tbl%0d_tick", i), 64'(frame_tick), 64'(tbl[i].tick));
      chk($sformatf("tbl%0d_idle", i), {data, wr_ready}, 64'd1);
    end
    chk("tick_count_64", 64'(ticks), 64'd2);

    // Commit with a second word held under back-pressure.
    wait_scan(3'd2);
    wr_valid = 1'b1;
    wr_data  = 32'h1234_5678;
    wr_le    = 8'hFF;
    wr_point = 8'h01;
    cyc();
    chk("c_ready_low", 64'(wr_ready), 64'd0);
    chk("c_data_old", 64'(data), 64'd0);
    wr_data  = 32'hDEAD_BEEF;
    wr_le    = 8'h0F;
    wr_point = 8'h80;
    wait_tick();
    chk("c_hold_tick", 64'(data), 64'd0);
    chk("bp_ready_tick", 64'(wr_ready), 64'd0);
    cyc();
    chk("c_commit", {data, le, point}, {16'h0, 32'h1234_5678, 8'hFF, 8'h01});
    chk("c_scan0", 64'(scan), 64'd0);
    chk("c_ready_back", 64'(wr_ready), 64'd1);
    vis = 1;
    cyc();
    vis++;
    chk("bp_accept", 64'(wr_ready), 64'd0);
    wr_valid = 1'b0;
    while (frame_tick !== 1'b1 && vis < 40) begin
      cyc();
      if (data === 32'h1234_5678) vis++;
    end
    cyc();
    chk("bp_visible", 64'(vis), 64'(FRAME));
    chk("bp_commit", {data, le, point}, {16'h0, 32'hDEAD_BEEF, 8'h0F, 8'h80});

    // Write accepted on the frame_tick cycle itself.
    wait_tick();
    wr_valid = 1'b1;
    wr_data  = 32'hCAFE_0001;
    wr_le    = 8'h3C;
    wr_point = 8'h00;
    cyc();
    wr_valid = 1'b0;
    chk("bd_accept", 64'(wr_ready), 64'd0);
    chk("bd_nobypass", 64'(data), 64'hDEAD_BEEF);
    wait_tick();
    chk("bd_hold", 64'(data), 64'hDEAD_BEEF);
    cyc();
    chk("bd_commit", {data, le}, {24'h0, 32'hCAFE_0001, 8'h3C});

    // Flash phase.
    flash_en = 1'b1;
    wait_tick(); cyc();
    chk("fl_t1", 64'(flash), 64'd0);
    wait_tick(); cyc();
    chk("fl_t2", 64'(flash), 64'(FL));
    wait_tick(); cyc();
    chk("fl_t3", 64'(flash), 64'(FL));
    wait_tick(); cyc();
    chk("fl_t4", 64'(flash), 64'd0);
    wait_tick(); cyc();
    wait_tick(); cyc();
    chk("fl_t6", 64'(flash), 64'(FL));
    flash_en = 1'b0;
    cyc();
    chk("fl_off", 64'(flash), 64'd0);

    // Reset mid-frame with a write pending.
    wait_scan(3'd4);
    wr_valid = 1'b1;
    wr_data  = 32'hA5A5_A5A5;
    wr_le    = 8'h55;
    wr_point = 8'hAA;
    cyc();
    wr_valid = 1'b0;
    chk("mr_pending", 64'(wr_ready), 64'd0);
    wait_scan(3'd5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_scan", 64'(scan), 64'd0);
    chk("mr_data", {data, le, point}, '0);
    chk("mr_ready", 64'(wr_ready), 64'd1);
    repeat (2 * FRAME + 4) cyc();
    chk("mr_dropped", {data, le, point}, '0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (!wr_valid && $urandom_range(3) == 0) begin
        wr_valid = 1'b1;
        wr_data  = $urandom;
        wr_le    = 8'($urandom);
        wr_point = 8'($urandom);
      end
      rst = ($urandom_range(400) == 0);
      if ($urandom_range(150) == 0) flash_en = !flash_en;
      cyc();
      if (m_acc) wr_valid = 1'b0;
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
